// File: rtl/i2s_rx.sv
// -----------------------------------------------------------------------------
// i2s_rx : I2S (Philips format) receiver for the ADC path.
//
// Samples sdi on rising edges of sclk (observed in the clk domain) and assembles
// DW-bit signed left/right words, MSB first. The data is delayed one sclk after
// each lrclk edge. Each complete stereo pair is presented on a valid/ready
// output register.
//
// Parameters
//   DW        sample width (output word width)
//   SLOT_MAX  largest expected bit count per lrclk half-period; the bit counter
//             saturates at this value
//
// Ports
//   clk_i         system clock; sclk/lrclk/sdi are sampled in this domain
//   rst_i         synchronous, active-high reset
//   sclk_i        I2S bit clock
//   lrclk_i       word select (0 = left, 1 = right)
//   sdi_i         serial data
//   l_sample_o    left sample of the last complete frame
//   r_sample_o    right sample of the last complete frame
//   valid_o       a pair is available; held until accepted
//   ready_i       consumer accepts the pair when valid_o & ready_i
//   overrun_o     1-cycle pulse: a new pair replaced one that was not accepted
//
// Build option
//   I2S_RX_SYNC_EN  when defined, sclk/lrclk/sdi each pass a 2-flop synchronizer
//                   before edge detection. Use this for an external or
//                   asynchronous bit clock; sclk must be <= clk/4 and commit
//                   latency grows by 2 clk. When undefined, the inputs are used
//                   directly (same-domain clock generator, sclk <= clk/2).
// -----------------------------------------------------------------------------
module i2s_rx #(
    parameter int DW       = 24,
    parameter int SLOT_MAX = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          sclk_i,
    input  logic          lrclk_i,
    input  logic          sdi_i,
    output logic [DW-1:0] l_sample_o,
    output logic [DW-1:0] r_sample_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          overrun_o
);

    // The counter must be able to hold both DW and SLOT_MAX.
    localparam int CMAX = (SLOT_MAX > DW) ? SLOT_MAX : DW;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] DW_C  = CW'(DW);
    localparam logic [CW-1:0] SAT_C = CW'(SLOT_MAX);

    typedef enum logic [1:0] {ALIGN, LEFT, RIGHT} state_t;

    // ------------------------------------------------------------------
    // Input stage
    // ------------------------------------------------------------------
    logic sclk_s, lrclk_s, sdi_s;

`ifdef I2S_RX_SYNC_EN
    logic [1:0] sclk_sync_q, lrclk_sync_q, sdi_sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync_q  <= '0;
            lrclk_sync_q <= '0;
            sdi_sync_q   <= '0;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[0],  sclk_i};
            lrclk_sync_q <= {lrclk_sync_q[0], lrclk_i};
            sdi_sync_q   <= {sdi_sync_q[0],   sdi_i};
        end
    end

    assign sclk_s  = sclk_sync_q[1];
    assign lrclk_s = lrclk_sync_q[1];
    assign sdi_s   = sdi_sync_q[1];
`else
    assign sclk_s  = sclk_i;
    assign lrclk_s = lrclk_i;
    assign sdi_s   = sdi_i;
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic          sclk_q;
    logic          lr_prev_q, lr_prev_d;
    logic [DW-1:0] shift_q, shift_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] l_hold_q, l_hold_d;
    logic [DW-1:0] r_hold_q, r_hold_d;
    logic          commit_q, commit_d;
    logic [DW-1:0] l_q, l_d, r_q, r_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;

    logic          rise, lr_edge;
    logic [DW-1:0] shift_in, word;
    logic [CW-1:0] pad;

    assign rise     = sclk_s & ~sclk_q;
    assign lr_edge  = rise & (lrclk_s ^ lr_prev_q);
    assign shift_in = {shift_q[DW-2:0], sdi_s};

    // Completed slot word. The bit sampled on the lrclk-edge rise is the
    // slot's LSB, so cnt_q+1 bits are in hand. A short slot is left-aligned
    // with zero fill. When the slot is longer than DW, the extra bits have
    // already been dropped.
    always_comb begin
        pad  = '0;
        word = shift_q;
        if (cnt_q < DW_C - CW'(1)) begin
            pad  = DW_C - cnt_q - CW'(1);
            word = shift_in << pad;
        end else if (cnt_q < DW_C) begin
            word = shift_in;
        end
    end

    // Capture / alignment FSM
    always_comb begin
        state_d   = state_q;
        lr_prev_d = lr_prev_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        l_hold_d  = l_hold_q;
        r_hold_d  = r_hold_q;
        commit_d  = 1'b0;
        if (rise) begin
            lr_prev_d = lrclk_s;
            if (lr_edge) begin
                shift_d = '0;
                cnt_d   = '0;
                unique case (state_q)
                    // Only a 1->0 edge starts a frame; anything before it is dropped.
                    ALIGN: if (!lrclk_s) state_d = LEFT;
                    LEFT: begin
                        l_hold_d = word;
                        state_d  = RIGHT;
                    end
                    RIGHT: begin
                        r_hold_d = word;
                        commit_d = 1'b1;
                        state_d  = LEFT;
                    end
                    default: state_d = ALIGN;
                endcase
            end else begin
                if (cnt_q < DW_C)  shift_d = shift_in;
                if (cnt_q < SAT_C) cnt_d   = cnt_q + CW'(1);
            end
        end
    end

    // Output register / handshake. A commit takes priority over an accept in
    // the same cycle. The overrun flag fires only when the old pair was
    // still pending and is not being taken now.
    always_comb begin
        l_d     = l_q;
        r_d     = r_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (valid_q && ready_i) valid_d = 1'b0;
        if (commit_q) begin
            l_d     = l_hold_q;
            r_d     = r_hold_q;
            valid_d = 1'b1;
            ovr_d   = valid_q & ~ready_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ALIGN;
            sclk_q    <= 1'b0;
            lr_prev_q <= 1'b0;
            shift_q   <= '0;
            cnt_q     <= '0;
            l_hold_q  <= '0;
            r_hold_q  <= '0;
            commit_q  <= 1'b0;
            l_q       <= '0;
            r_q       <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sclk_q    <= sclk_s;
            lr_prev_q <= lr_prev_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            l_hold_q  <= l_hold_d;
            r_hold_q  <= r_hold_d;
            commit_q  <= commit_d;
            l_q       <= l_d;
            r_q       <= r_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
        end
    end

    assign l_sample_o = l_q;
    assign r_sample_o = r_q;
    assign valid_o    = valid_q;
    assign overrun_o  = ovr_q;

endmodule
